// File: rtl/mxv_stream_engine.sv
// mxv_stream_engine: framed byte-stream matrix x vector engine, one MAC.
// Build option MXV_SIGNED_EN: two's-complement elements and results.
module mxv_stream_engine #(
   parameter int DW         = 8,
   parameter int MAX_N      = 8,
   parameter int OUT_CHUNKS = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] rx_data,
   input  logic          rx_valid,
   output logic [DW-1:0] tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic [2:0]    cmd_out,
   output logic          err,
   output logic          busy
);

   localparam int ACCW = DW * OUT_CHUNKS;
   localparam int NW   = $clog2(MAX_N + 1);
   localparam int IW   = (MAX_N > 1) ? $clog2(MAX_N) : 1;
   localparam int CW   = (OUT_CHUNKS > 1) ? $clog2(OUT_CHUNKS) : 1;

   localparam logic [DW-1:0] HDR = DW'(8'hFE);
   localparam logic [DW-1:0] TLR = DW'(8'hEF);

   typedef enum logic [2:0] {
      IDLE,
      GET_CMD,
      GET_LEN,
      PAYLOAD,
      TAIL,
      TX_HDR,
      TX_DATA,
      TX_TAIL
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   err_nxt;

   logic [2:0]      cmd;
   logic [DW-1:0]   cnt;
   logic [DW-1:0]   n_cand;
   logic [DW-1:0]   len_req;
   logic [NW-1:0]   n;
   logic [NW-1:0]   n_res;
   logic [2*NW-1:0] nn;
   logic [IW-1:0]   row;
   logic [IW-1:0]   col;
   logic [IW-1:0]   n_last;
   logic [IW-1:0]   res_last;
   logic [IW-1:0]   tx_row;
   logic [CW-1:0]   tx_chk;
   logic            result_valid;

   logic [DW-1:0]   v   [MAX_N];
   logic [ACCW-1:0] res [MAX_N];

   logic [DW-1:0]   v_sel;
   logic [ACCW-1:0] a_ext;
   logic [ACCW-1:0] b_ext;
   logic [ACCW-1:0] prod;
   logic [ACCW-1:0] cur;
   logic [DW-1:0]   chunk;

   logic cmd_ok;
   logic tail_ok;
   logic n_ok;
   logic good_tail;
   logic len_ok;
   logic tx_fire;
   logic tx_end;

   assign nn       = {{NW{1'b0}}, n} * {{NW{1'b0}}, n};
   assign n_last   = IW'(n - NW'(1));
   assign res_last = IW'(n_res - NW'(1));
   assign v_sel    = v[col];

`ifdef MXV_SIGNED_EN
   assign a_ext = {{(ACCW-DW){rx_data[DW-1]}}, rx_data};
   assign b_ext = {{(ACCW-DW){v_sel[DW-1]}}, v_sel};
`else
   assign a_ext = {{(ACCW-DW){1'b0}}, rx_data};
   assign b_ext = {{(ACCW-DW){1'b0}}, v_sel};
`endif

   // Single multiplier; product wraps to the accumulator width.
   assign prod = a_ext * b_ext;

   assign cmd_ok  = (rx_data >= DW'(1)) && (rx_data <= DW'(4));
   assign n_ok    = (n_cand >= DW'(1)) && (n_cand <= DW'(MAX_N));
   assign tail_ok = (rx_data == TLR);
   assign len_ok  = (rx_data == len_req);
   assign tx_fire = tx_valid && tx_ready;
   assign tx_end  = (tx_row == res_last)
                 && (tx_chk == CW'(OUT_CHUNKS - 1));
   assign busy    = (state != IDLE);

   // Required LEN and tail acceptance for the command in flight.
   always_comb begin
      len_req   = '0;
      good_tail = tail_ok;
      unique case (1'b1)
         (cmd == 3'd1): begin
            len_req   = DW'(1);
            good_tail = tail_ok && n_ok;
         end
         (cmd == 3'd2): begin
            len_req   = '0;
            good_tail = tail_ok && result_valid;
         end
         (cmd == 3'd3): len_req = DW'(n);
         (cmd == 3'd4): len_req = DW'(nn);
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state and error strobe.
   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (rx_valid && rx_data == HDR)
               state_nxt = GET_CMD;
         end
         GET_CMD: begin
            if (rx_valid) begin
               if (cmd_ok) begin
                  state_nxt = GET_LEN;
               end else begin
                  state_nxt = IDLE;
                  err_nxt   = 1'b1;
               end
            end
         end
         GET_LEN: begin
            if (rx_valid) begin
               if (!len_ok) begin
                  state_nxt = IDLE;
                  err_nxt   = 1'b1;
               end else if (rx_data == '0) begin
                  state_nxt = TAIL;
               end else begin
                  state_nxt = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (rx_valid && cnt == DW'(1))
               state_nxt = TAIL;
         end
         TAIL: begin
            if (rx_valid) begin
               if (!good_tail) begin
                  state_nxt = IDLE;
                  err_nxt   = 1'b1;
               end else if (cmd == 3'd2 || cmd == 3'd4) begin
                  state_nxt = TX_HDR;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         TX_HDR: begin
            err_nxt = rx_valid;
            if (tx_fire)
               state_nxt = TX_DATA;
         end
         TX_DATA: begin
            err_nxt = rx_valid;
            if (tx_fire && tx_end)
               state_nxt = TX_TAIL;
         end
         TX_TAIL: begin
            err_nxt = rx_valid;
            if (tx_fire)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Frame bookkeeping, committed configuration and Tx cursor.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err          <= 1'b0;
         cmd          <= '0;
         cmd_out      <= '0;
         cnt          <= '0;
         n_cand       <= '0;
         n            <= NW'(1);
         n_res        <= NW'(1);
         row          <= '0;
         col          <= '0;
         tx_row       <= '0;
         tx_chk       <= '0;
         result_valid <= 1'b0;
      end else begin
         err <= err_nxt;
         unique case (state)
            GET_CMD: begin
               if (rx_valid)
                  cmd <= rx_data[2:0];
            end
            GET_LEN: begin
               if (rx_valid) begin
                  cnt <= rx_data;
                  row <= '0;
                  col <= '0;
                  if (cmd == 3'd4 && len_ok)
                     result_valid <= 1'b0;
               end
            end
            PAYLOAD: begin
               if (rx_valid) begin
                  cnt <= cnt - DW'(1);
                  if (cmd == 3'd1)
                     n_cand <= rx_data;
                  if (col == n_last) begin
                     col <= '0;
                     row <= row + IW'(1);
                  end else begin
                     col <= col + IW'(1);
                  end
               end
            end
            TAIL: begin
               if (rx_valid && good_tail) begin
                  cmd_out <= cmd;
                  tx_row  <= '0;
                  tx_chk  <= '0;
                  if (cmd == 3'd1)
                     n <= NW'(n_cand);
                  if (cmd == 3'd4) begin
                     result_valid <= 1'b1;
                     n_res        <= n;
                  end
               end
            end
            TX_DATA: begin
               if (tx_fire) begin
                  if (tx_chk == CW'(OUT_CHUNKS - 1)) begin
                     tx_chk <= '0;
                     tx_row <= tx_row + IW'(1);
                  end else begin
                     tx_chk <= tx_chk + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Vector and result storage written from the payload stream.
   always_ff @(posedge clk) begin
      if (rst && state == PAYLOAD && rx_valid) begin
         if (cmd == 3'd3)
            v[col] <= rx_data;
         if (cmd == 3'd4) begin
            if (col == '0) res[row] <= prod;
            else           res[row] <= res[row] + prod;
         end
      end
   end

   // Chunk select, most significant chunk first.
   always_comb begin
      cur   = res[tx_row];
      chunk = '0;
      for (int k = 0; k < OUT_CHUNKS; k++) begin
         if (tx_chk == CW'(k))
            chunk = cur[ACCW-1-k*DW -: DW];
      end
   end

   // Outgoing byte for the current Tx state.
   always_comb begin
      tx_data  = '0;
      tx_valid = 1'b0;
      unique case (state)
         TX_HDR: begin
            tx_data  = HDR;
            tx_valid = 1'b1;
         end
         TX_DATA: begin
            tx_data  = chunk;
            tx_valid = 1'b1;
         end
         TX_TAIL: begin
            tx_data  = TLR;
            tx_valid = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mxv_stream_engine.sv
// tb_mxv_stream_engine: directed + random frames against a math model.
// Honours MXV_SIGNED_EN the same way as the design.
module tb_mxv_stream_engine;

   localparam int MAX_N = 8;
`ifdef MXV_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [2:0] cmd_out;
   logic       err;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   int err_cnt = 0;
   bq_t tx_q;

   int          m_n = 1;
   int          m_nres = 1;
   bit          m_rv = 1'b0;
   int          m_cmd = 0;
   logic [7:0]  m_v [MAX_N];
   logic [23:0] m_res [MAX_N];

   logic       pv = 1'b0;
   logic [7:0] pd = '0;

   mxv_stream_engine #(
      .DW(8), .MAX_N(MAX_N), .OUT_CHUNKS(3)
   ) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .cmd_out(cmd_out),
      .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change at posedge+1, so negedge sees the values of the next edge.
   always @(negedge clk) begin
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (err) err_cnt++;
      if (pv && rst)
         check("tx hold", {55'b0, tx_valid, tx_data}, {55'b0, 1'b1, pd});
      pv <= rst && tx_valid && !tx_ready;
      pd <= tx_data;
   end

   function automatic longint elem(input logic [7:0] x);
      if (SGN) return longint'($signed(x));
      return longint'(x);
   endfunction

   function automatic bq_t exp_tx();
      bq_t q;
      q.push_back(8'hFE);
      for (int r = 0; r < m_nres; r++) begin
         q.push_back(m_res[r][23:16]);
         q.push_back(m_res[r][15:8]);
         q.push_back(m_res[r][7:0]);
      end
      q.push_back(8'hEF);
      return q;
   endfunction

   function automatic bq_t rand_q(input int k);
      bq_t q;
      for (int i = 0; i < k; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic send(input bq_t q);
      foreach (q[i]) begin
         @(posedge clk); #1;
         rx_data = q[i];
         rx_valid = 1'b1;
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic check_bytes(input string tag, input bq_t exp);
      logic [63:0] obs;
      check({tag, " len"}, 64'(tx_q.size()), 64'(exp.size()));
      foreach (exp[i]) begin
         obs = (i < tx_q.size()) ? {56'b0, tx_q[i]} : 'x;
         check($sformatf("%s byte%0d", tag, i), obs, {56'b0, exp[i]});
      end
   endtask

   task automatic run_tx(input bq_t exp, input int mode,
                         input bit inject, input string tag);
      int e0;
      bit done;
      e0 = err_cnt;
      done = 1'b0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         @(posedge clk); #1;
         if (tx_q.size() >= exp.size() && !tx_valid) begin
            done = 1'b1;
         end else begin
            case (mode)
               0: tx_ready = 1'b1;
               1: tx_ready = 1'($urandom_range(0, 1));
               default: tx_ready = !(cyc >= 6 && cyc < 11);
            endcase
            rx_valid = inject && (cyc == 4);
            rx_data = 8'hFE;
         end
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      check({tag, " done"}, 64'(done), 64'd1);
      check_bytes(tag, exp);
      check({tag, " err"}, 64'(err_cnt - e0), 64'(inject));
      check({tag, " busy"}, 64'(busy), 64'd0);
   endtask

   task automatic do_set_n(input int nv);
      int e0;
      bit ok;
      e0 = err_cnt;
      ok = (nv >= 1 && nv <= MAX_N);
      send('{8'hFE, 8'h01, 8'h01, 8'(nv), 8'hEF});
      @(posedge clk); #1;
      if (ok) begin
         m_n = nv;
         m_cmd = 1;
      end
      check($sformatf("setn%0d err", nv), 64'(err_cnt - e0), 64'(!ok));
      check("setn cmd_out", 64'(cmd_out), 64'(m_cmd));
   endtask

   task automatic do_set_v(input bq_t vv);
      bq_t q;
      int e0;
      e0 = err_cnt;
      q = '{8'hFE, 8'h03, 8'(m_n)};
      for (int i = 0; i < m_n; i++) begin
         q.push_back(vv[i]);
         m_v[i] = vv[i];
      end
      q.push_back(8'hEF);
      send(q);
      @(posedge clk); #1;
      m_cmd = 3;
      check("setv err", 64'(err_cnt - e0), 64'd0);
      check("setv cmd_out", 64'(cmd_out), 64'(m_cmd));
   endtask

   task automatic do_mxv(input bq_t mq, input int mode,
                         input bit inject, input string tag);
      bq_t q;
      longint acc;
      q = '{8'hFE, 8'h04, 8'(m_n * m_n)};
      foreach (mq[i]) q.push_back(mq[i]);
      q.push_back(8'hEF);
      for (int r = 0; r < m_n; r++) begin
         acc = 0;
         for (int c = 0; c < m_n; c++)
            acc += elem(mq[r*m_n + c]) * elem(m_v[c]);
         m_res[r] = acc[23:0];
      end
      m_rv = 1'b1;
      m_nres = m_n;
      m_cmd = 4;
      tx_q.delete();
      send(q);
      run_tx(exp_tx(), mode, inject, tag);
      check({tag, " cmd_out"}, 64'(cmd_out), 64'(m_cmd));
   endtask

   task automatic do_resend(input int mode, input string tag);
      int e0;
      e0 = err_cnt;
      tx_q.delete();
      send('{8'hFE, 8'h02, 8'h00, 8'hEF});
      if (m_rv) begin
         m_cmd = 2;
         run_tx(exp_tx(), mode, 1'b0, tag);
      end else begin
         @(posedge clk); #1;
         check({tag, " err"}, 64'(err_cnt - e0), 64'd1);
         check({tag, " txq"}, 64'(tx_q.size()), 64'd0);
      end
      check({tag, " cmd_out"}, 64'(cmd_out), 64'(m_cmd));
   endtask

   task automatic bad_frame(input bq_t q, input string tag);
      int e0;
      e0 = err_cnt;
      send(q);
      @(posedge clk); #1;
      check({tag, " err"}, 64'(err_cnt - e0), 64'd1);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " cmd_out"}, 64'(cmd_out), 64'(m_cmd));
   endtask

   initial begin
      bq_t prev;
      bq_t ff;
      bq_t e;
      int e0;
      int nr;

      repeat (3) @(posedge clk);
      #1;
      check("rst busy", 64'(busy), 64'd0);
      check("rst tx_valid", 64'(tx_valid), 64'd0);
      check("rst tx_data", 64'(tx_data), 64'd0);
      check("rst err", 64'(err), 64'd0);
      check("rst cmd_out", 64'(cmd_out), 64'd0);
      rst = 1'b1;

      do_set_n(2);
      do_set_v('{8'd1, 8'd2});
      do_mxv('{8'd3, 8'd4, 8'd5, 8'd6}, 0, 1'b0, "mxv2");
      check_bytes("plan1", '{8'hFE, 8'h00, 8'h00, 8'h0B,
                             8'h00, 8'h00, 8'h11, 8'hEF});

      do_set_n(9);
      do_set_n(0);
      bad_frame('{8'hFE, 8'h04, 8'h09}, "len9");
      do_mxv(rand_q(4), 1, 1'b1, "mxv2 rx-in-tx");
      bad_frame('{8'hFE, 8'h07}, "badcmd");

      e0 = err_cnt;
      send('{8'h00, 8'h55, 8'hEF, 8'h01});
      @(posedge clk); #1;
      check("idle junk err", 64'(err_cnt - e0), 64'd0);
      check("idle junk busy", 64'(busy), 64'd0);

      bad_frame('{8'hFE, 8'h04, 8'h04, 8'h01, 8'h02,
                  8'h03, 8'h04, 8'hEE}, "badtail");
      m_rv = 1'b0;
      do_resend(0, "resend-invalid");

      do_mxv(rand_q(4), 1, 1'b0, "mxv2 rnd");
      prev = tx_q;
      do_resend(1, "resend");
      check_bytes("resend same", prev);

      do_set_n(8);
      ff = '{};
      for (int i = 0; i < 64; i++) ff.push_back(8'hFF);
      do_set_v(ff);
      do_mxv(ff, 2, 1'b0, "hold");
      e = '{8'hFE};
      for (int r = 0; r < 8; r++) begin
         if (SGN) e = {e, 8'h00, 8'h00, 8'h08};
         else     e = {e, 8'h07, 8'hF0, 8'h08};
      end
      e.push_back(8'hEF);
      check_bytes("ff8", e);

      do_set_n(1);
      do_set_v('{8'hFF});
      do_mxv('{8'hFF}, 0, 1'b0, "sign");
      if (SGN) e = '{8'hFE, 8'h00, 8'h00, 8'h01, 8'hEF};
      else     e = '{8'hFE, 8'h00, 8'hFE, 8'h01, 8'hEF};
      check_bytes("sign const", e);

      for (int it = 0; it < 8; it++) begin
         nr = int'($urandom_range(1, MAX_N));
         do_set_n(nr);
         do_set_v(rand_q(nr));
         do_mxv(rand_q(nr * nr), 1, 1'(it % 2), $sformatf("rnd%0d", it));
         if (it % 3 == 0) do_resend(1, $sformatf("rnd%0d re", it));
      end

      do_set_n(3);
      do_set_v(rand_q(3));
      foreach (e[i]) e[i] = 8'h00;
      e = '{8'hFE, 8'h04, 8'h09, 8'h11, 8'h22};
      foreach (e[i]) begin
         @(posedge clk); #1;
         rx_data = e[i];
         rx_valid = 1'b1;
      end
      @(posedge clk); #1;
      rx_data = 8'h33;
      rst = 1'b0;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      check("mid rst busy", 64'(busy), 64'd0);
      check("mid rst tx_valid", 64'(tx_valid), 64'd0);
      check("mid rst cmd_out", 64'(cmd_out), 64'd0);
      rst = 1'b1;
      m_n = 1;
      m_rv = 1'b0;
      m_cmd = 0;
      do_resend(0, "post-rst resend");
      do_set_v(rand_q(1));
      do_mxv(rand_q(1), 0, 1'b0, "post-rst mxv");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mxv_stream_engine.md
Name: mxv_stream_engine

Overview:
- Parametrised successor to the fixed-size matrix-by-vector datapath.
- Consumes a framed byte stream from the UART receiver and runs runtime-sized (1..MAX_N) unsigned matrix×vector products with a single multiply-accumulate unit.
- Returns framed results to the UART transmitter over a valid/ready handshake.
- Retains the last result for resend. Sits between UART Rx/Tx and the board command LEDs.

Parameters:
- DW, 8: stream byte width and matrix/vector element width.
- MAX_N, 8: maximum matrix dimension; MAX_N*MAX_N must be ≤ 2^DW-1.
- OUT_CHUNKS, 3: DW-wide chunks per result; accumulator width ACCW = DW*OUT_CHUNKS.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-low reset.
- rx_data  in  DW  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle. May assert on consecutive cycles.
- tx_data  out  DW  byte to transmit.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts; a transfer occurs when tx_valid && tx_ready.
- cmd_out  out  3  code of the last correctly framed command.
- err  out  1  one-cycle pulse on any protocol error.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs are 0; N=1; result_valid=0; FSM=IDLE. Reset mid-frame or mid-Tx abandons it immediately; no partial byte is held.
- Frame format: 0xFE, CMD, LEN, LEN payload bytes, 0xEF.
- FSM states: IDLE, GET_CMD, GET_LEN, PAYLOAD, TAIL, TX_HDR, TX_DATA, TX_TAIL.
  - IDLE: waits for 0xFE; other bytes are silently dropped.
  - GET_CMD: CMD outside {1,2,3,4} → err.
  - GET_LEN: required LEN is CMD1=1, CMD2=0, CMD3=N, CMD4=N*N. Mismatch → err. LEN=0 goes directly to TAIL.
  - PAYLOAD:
    - CMD1: latch candidate N.
    - CMD3: write v[idx].
    - CMD4: element (r,c) arrives row-major. c=0 → res[r] := m*v[0]; otherwise res[r] := res[r] + m*v[c]. Applied in the accepting cycle. ACCW-bit unsigned arithmetic, wraps modulo 2^ACCW.
  - TAIL: byte ≠ 0xEF → err.
    - CMD1 commits N only if 1 ≤ N ≤ MAX_N; otherwise err.
    - CMD2 with result_valid=0 → err.
    - CMD4 sets result_valid=1.
    - CMD2 and CMD4 proceed to TX_HDR; CMD1 and CMD3 return to IDLE.
    - cmd_out updates on every good tail.
- result_valid clears when CMD4 reaches PAYLOAD. A CMD4 frame that errors leaves results invalid. A CMD3 frame that errors leaves v partially written.
- Tx sequence: 0xFE, then res[0..N-1], each as OUT_CHUNKS chunks MSB-first, then 0xEF. Total N*OUT_CHUNKS+2 bytes.
  - tx_valid rises the cycle after the good tail.
  - tx_data is held stable until accepted; the next byte is presented the cycle after a transfer.
  - tx_valid drops the cycle after the 0xEF transfer.
- rx_valid during the TX_* states: byte dropped and err pulses; the Tx sequence continues.
- err: one-cycle pulse; FSM returns to IDLE in the same edge. An error byte equal to 0xFE is not reinterpreted as a header.
- N changes take effect for the next frame only. res is only defined for indices below the N used by the last CMD4.

Optional Feature:
- Macro: MXV_SIGNED_EN.
- Defined: elements are two's-complement; products are sign-extended to ACCW; results are transmitted as ACCW-bit two's-complement.
- Undefined: unsigned arithmetic as above.

Test Plan:
- Set N=2, v=[1,2], then CMD4 with M=[3,4,5,6] (FE 04 04 03 04 05 06 EF) → Tx FE 00 00 0B 00 00 11 EF; cmd_out=4; result_valid=1.
- Frame FE 01 01 09 EF with MAX_N=8 → err pulse; N stays 2; cmd_out unchanged; next CMD4 still requires LEN=4.
- CMD4 frame with tail 0xEE → err; FE 02 00 EF afterwards → err (result_valid=0). After a good CMD4, FE 02 00 EF → identical Tx bytes again.
- N=8, all elements 0xFF → each result 0x07F008 (bytes 07 F0 08); hold tx_ready=0 for 5 cycles mid-stream → tx_data stable, no byte lost or duplicated.
- Reset asserted on the 3rd payload byte, then FE 02 00 EF → err; busy=0 and tx_valid=0 immediately after reset.
- MXV_SIGNED_EN defined, N=1, v=[0xFF], M=[0xFF] → Tx FE 00 00 01 EF. Same stimulus without the macro → FE 00 FE 01 EF.
